// File: rtl/mouse_init_ctrl.sv
// PS/2 mouse bring-up: reset, self-test, optional sample rate, stream enable.
// Define MOUSE_INIT_SAMPLE_RATE_EN to send 0xF3/SAMPLE_RATE before 0xF4.
module mouse_init_ctrl #(
  parameter int         ACK_TO      = 2000000,
  parameter int         BAT_TO      = 60000000,
  parameter int         MAX_RETRY   = 3,
  parameter logic [7:0] SAMPLE_RATE = 8'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       tx_valid,
  output logic [7:0] tx_byte,
  input  logic       tx_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       stream_en,
  output logic       init_err,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_ACK = 3'd2,
    WAIT_BAT = 3'd3,
    WAIT_ID  = 3'd4,
    STREAM   = 3'd5,
    FAIL     = 3'd6
  } state_t;

`ifdef MOUSE_INIT_SAMPLE_RATE_EN
  localparam logic [1:0] ID_NEXT = 2'd1;
`else
  localparam logic [1:0] ID_NEXT = 2'd3;
`endif

  state_t      state;
  logic [1:0]  idx;
  logic [25:0] timer;

  logic        waiting;
  logic [7:0]  exp_byte;
  logic        good;
  logic        resend;
  logic        fail;
  logic        exhausted;
  logic [1:0]  fail_idx;

  function automatic logic [7:0] cmd(input logic [1:0] i);
    logic [7:0] b;
    unique case (i)
      2'd0:    b = 8'hFF;
      2'd1:    b = 8'hF3;
      2'd2:    b = SAMPLE_RATE;
      default: b = 8'hF4;
    endcase
    return b;
  endfunction

  assign state_dbg = state;

  always_comb begin
    waiting  = 1'b0;
    exp_byte = 8'hFA;
    unique case (1'b1)
      (state == WAIT_ACK): waiting = 1'b1;
      (state == WAIT_BAT): begin
        waiting  = 1'b1;
        exp_byte = 8'hAA;
      end
      (state == WAIT_ID): begin
        waiting  = 1'b1;
        exp_byte = 8'h00;
      end
      default: ;
    endcase
    good   = waiting && rx_valid && (rx_byte == exp_byte);
    resend = (state == WAIT_ACK) && rx_valid
             && (rx_byte == 8'hFE);
    // a byte arriving on the expiry cycle wins over the timeout
    fail   = waiting && !good
             && (rx_valid || (timer == '0));
    fail_idx  = resend ? idx : 2'd0;
    exhausted = int'(retry_cnt) >= MAX_RETRY;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      timer     <= '0;
      tx_valid  <= 1'b0;
      tx_byte   <= 8'h00;
      stream_en <= 1'b0;
      init_err  <= 1'b0;
      retry_cnt <= 2'd0;
    end else if (start) begin
      state     <= IDLE;
      idx       <= 2'd0;
      timer     <= '0;
      tx_valid  <= 1'b0;
      stream_en <= 1'b0;
      init_err  <= 1'b0;
      retry_cnt <= 2'd0;
    end else if (fail) begin
      if (exhausted) begin
        state     <= FAIL;
        init_err  <= 1'b1;
        tx_valid  <= 1'b0;
        retry_cnt <= 2'd3;
      end else begin
        state     <= SEND;
        idx       <= fail_idx;
        retry_cnt <= retry_cnt + 2'd1;
        tx_valid  <= 1'b1;
        tx_byte   <= cmd(fail_idx);
      end
    end else begin
      unique case (state)
        IDLE: begin
          state    <= SEND;
          idx      <= 2'd0;
          tx_valid <= 1'b1;
          tx_byte  <= cmd(2'd0);
        end
        SEND: begin
          if (tx_ready) begin
            state    <= WAIT_ACK;
            tx_valid <= 1'b0;
            timer    <= 26'(ACK_TO);
          end
        end
        WAIT_ACK: begin
          if (good) begin
            if (idx == 2'd0) begin
              state <= WAIT_BAT;
              timer <= 26'(BAT_TO);
            end else if (idx == 2'd3) begin
              state     <= STREAM;
              stream_en <= 1'b1;
              retry_cnt <= 2'd0;
            end else begin
              state    <= SEND;
              idx      <= idx + 2'd1;
              tx_valid <= 1'b1;
              tx_byte  <= cmd(idx + 2'd1);
            end
          end else begin
            timer <= timer - 26'd1;
          end
        end
        WAIT_BAT: begin
          if (good) begin
            state <= WAIT_ID;
            timer <= 26'(BAT_TO);
          end else begin
            timer <= timer - 26'd1;
          end
        end
        WAIT_ID: begin
          if (good) begin
            state    <= SEND;
            idx      <= ID_NEXT;
            tx_valid <= 1'b1;
            tx_byte  <= cmd(ID_NEXT);
          end else begin
            timer <= timer - 26'd1;
          end
        end
        STREAM: ;
        FAIL: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_init_ctrl.sv
// Bench for mouse_init_ctrl: transaction-level mouse model with
// directed scripts and randomized replies/delays.
module tb_mouse_init_ctrl;

  localparam int ACK_TO = 16;
  localparam int BAT_TO = 40;

  localparam int P_SEND   = 0;
  localparam int P_ACK    = 1;
  localparam int P_BAT    = 2;
  localparam int P_ID     = 3;
  localparam int P_STREAM = 4;
  localparam int P_FAIL   = 5;

  localparam int K_GOOD = 0;
  localparam int K_FE   = 1;
  localparam int K_FC   = 2;
  localparam int K_BAD  = 3;
  localparam int K_TMO  = 4;

`ifdef MOUSE_INIT_SAMPLE_RATE_EN
  localparam int ID_NEXT = 1;
`else
  localparam int ID_NEXT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ready = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       stream_en;
  logic       init_err;
  logic [1:0] retry_cnt;
  logic [2:0] state_dbg;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] cmd_list [4];
  int m_phase;
  int m_idx;
  int m_retry;
  int script[$];

  mouse_init_ctrl #(
    .ACK_TO(ACK_TO),
    .BAT_TO(BAT_TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .tx_valid(tx_valid),
    .tx_byte(tx_byte),
    .tx_ready(tx_ready),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .stream_en(stream_en),
    .init_err(init_err),
    .retry_cnt(retry_cnt),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int state_code(input int ph);
    case (ph)
      P_SEND:   return 1;
      P_ACK:    return 2;
      P_BAT:    return 3;
      P_ID:     return 4;
      P_STREAM: return 5;
      default:  return 6;
    endcase
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ":state"}, 32'(state_dbg), state_code(m_phase));
    chk({tag, ":retry"}, 32'(retry_cnt), m_retry);
    chk({tag, ":stream_en"}, 32'(stream_en), 32'(m_phase == P_STREAM));
    chk({tag, ":init_err"}, 32'(init_err), 32'(m_phase == P_FAIL));
    chk({tag, ":tx_valid"}, 32'(tx_valid), 32'(m_phase == P_SEND));
  endtask

  task automatic model_fail(input int new_idx);
    if (m_retry >= 3) begin
      m_phase = P_FAIL;
      m_retry = 3;
    end else begin
      m_retry++;
      m_idx   = new_idx;
      m_phase = P_SEND;
    end
  endtask

  task automatic model_reply(input int kind);
    case (m_phase)
      P_ACK: begin
        if (kind == K_GOOD) begin
          if (m_idx == 0) m_phase = P_BAT;
          else if (m_idx == 3) begin
            m_phase = P_STREAM;
            m_retry = 0;
          end else begin
            m_idx++;
            m_phase = P_SEND;
          end
        end else if (kind == K_FE) model_fail(m_idx);
        else model_fail(0);
      end
      P_BAT: begin
        if (kind == K_GOOD) m_phase = P_ID;
        else model_fail(0);
      end
      P_ID: begin
        if (kind == K_GOOD) begin
          m_idx   = ID_NEXT;
          m_phase = P_SEND;
        end else model_fail(0);
      end
      default: ;
    endcase
  endtask

  task automatic model_init();
    m_phase = P_SEND;
    m_idx   = 0;
    m_retry = 0;
  endtask

  task automatic do_send();
    logic [7:0] exp;
    int hold;
    exp  = cmd_list[m_idx];
    hold = $urandom_range(0, 2);
    chk("offer:tx_valid", 32'(tx_valid), 1);
    chk("offer:tx_byte", 32'(tx_byte), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold:tx_valid", 32'(tx_valid), 1);
      chk("hold:tx_byte", 32'(tx_byte), 32'(exp));
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    m_phase = P_ACK;
    check_model("xfer");
  endtask

  task automatic do_wait(input int kind);
    logic [7:0] g;
    logic [7:0] b;
    int to;
    int d;
    g  = (m_phase == P_ACK) ? 8'hFA :
         (m_phase == P_BAT) ? 8'hAA : 8'h00;
    to = (m_phase == P_ACK) ? ACK_TO : BAT_TO;
    if (kind == K_TMO) begin
      for (int i = 0; i < to; i++) tick();
      chk("pre_timeout:state", 32'(state_dbg), state_code(m_phase));
      tick();
    end else begin
      d = ($urandom_range(0, 3) == 0) ? to : $urandom_range(0, to);
      case (kind)
        K_GOOD: b = g;
        K_FE:   b = 8'hFE;
        K_FC:   b = 8'hFC;
        default: begin
          b = 8'($urandom);
          if (b == g || b == 8'hFE) b = g ^ 8'h5A;
        end
      endcase
      for (int i = 0; i < d; i++) tick();
      chk("pre_rx:stream_en", 32'(stream_en), 0);
      rx_valid = 1'b1;
      rx_byte  = b;
      tick();
      rx_valid = 1'b0;
      rx_byte  = 8'($urandom);
    end
    model_reply(kind);
    check_model("reply");
  endtask

  function automatic int pick_kind();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return K_GOOD;
    if (r < 78) return K_FE;
    if (r < 85) return K_FC;
    if (r < 92) return K_BAD;
    return K_TMO;
  endfunction

  task automatic run();
    int kind;
    for (int it = 0; it < 40 && m_phase < P_STREAM; it++) begin
      if (m_phase == P_SEND) do_send();
      if (script.size() > 0) kind = script.pop_front();
      else kind = pick_kind();
      do_wait(kind);
    end
    script.delete();
  endtask

  task automatic do_start(input logic with_rx);
    start = 1'b1;
    if (with_rx) begin
      rx_valid = 1'b1;
      rx_byte  = 8'hFA;
    end
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    chk("start:state", 32'(state_dbg), 0);
    chk("start:stream_en", 32'(stream_en), 0);
    chk("start:init_err", 32'(init_err), 0);
    chk("start:retry", 32'(retry_cnt), 0);
    chk("start:tx_valid", 32'(tx_valid), 0);
    tick();
    model_init();
    check_model("start_send");
    chk("start_send:tx_byte", 32'(tx_byte), 32'hFF);
  endtask

  initial begin
    cmd_list[0] = 8'hFF;
    cmd_list[1] = 8'hF3;
    cmd_list[2] = 8'd100;
    cmd_list[3] = 8'hF4;

    // reset values
    for (int i = 0; i < 3; i++) tick();
    chk("rst:state", 32'(state_dbg), 0);
    chk("rst:tx_valid", 32'(tx_valid), 0);
    chk("rst:tx_byte", 32'(tx_byte), 0);
    chk("rst:stream_en", 32'(stream_en), 0);
    chk("rst:init_err", 32'(init_err), 0);
    chk("rst:retry", 32'(retry_cnt), 0);
    rst = 1'b1;
    tick();
    model_init();
    check_model("post_rst");
    chk("post_rst:tx_byte", 32'(tx_byte), 32'hFF);

    // nominal run
    script = '{K_GOOD, K_GOOD, K_GOOD, K_GOOD, K_GOOD, K_GOOD};
    run();
    chk("nominal:stream_en", 32'(stream_en), 1);

    // stream ignores received bytes
    rx_valid = 1'b1;
    rx_byte  = 8'hFE;
    tick();
    rx_valid = 1'b0;
    check_model("stream_rx");

    // start beats a simultaneous FA in STREAM
    do_start(1'b1);

    // resend on FE for the second command
    script = '{K_GOOD, K_GOOD, K_GOOD, K_FE,
               K_GOOD, K_GOOD, K_GOOD, K_GOOD};
    run();

    // four timeouts reach FAIL
    do_start(1'b0);
    script = '{K_TMO, K_TMO, K_TMO, K_TMO};
    run();
    chk("tmo:state", 32'(state_dbg), 6);
    chk("tmo:init_err", 32'(init_err), 1);
    chk("tmo:retry", 32'(retry_cnt), 3);
    rx_valid = 1'b1;
    rx_byte  = 8'hFA;
    tick();
    rx_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_model("fail_hold");

    // bad self-test restarts at 0xFF
    do_start(1'b0);
    script = '{K_GOOD, K_FC};
    run();

    // reset during an offered transfer
    do_start(1'b0);
    tx_ready = 1'b1;
    rst      = 1'b0;
    tick();
    tx_ready = 1'b0;
    chk("mid_rst:tx_valid", 32'(tx_valid), 0);
    chk("mid_rst:state", 32'(state_dbg), 0);
    rst = 1'b1;
    tick();
    model_init();
    check_model("mid_rst_resume");
    chk("mid_rst_resume:tx_byte", 32'(tx_byte), 32'hFF);
    run();

    // randomized sessions
    for (int n = 0; n < 20; n++) begin
      do_start(1'b0);
      run();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
